// File: rtl/motor_arb_pkg.sv
// motor_arb_pkg: shared constants and types for motor_mode_arbiter.
//   - IdleCmd: all-inactive command (active-low drive, so all ones)
//   - Cmd*: bit positions of each field inside a 6-bit command slice
//   - arb_state_e: arbiter FSM states (StLoss exists only with MOTOR_ARB_WDOG_EN)
//   - min_width(): counter/index width helper, never narrower than one bit
package motor_arb_pkg;

    localparam logic [5:0] IdleCmd = 6'b111111;

    localparam int unsigned CmdEna = 5;
    localparam int unsigned CmdEnb = 4;
    localparam int unsigned CmdIn1 = 3;
    localparam int unsigned CmdIn2 = 2;
    localparam int unsigned CmdIn3 = 1;
    localparam int unsigned CmdIn4 = 0;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StDead = 2'd1
`ifdef MOTOR_ARB_WDOG_EN
        , StLoss = 2'd2
`endif
    } arb_state_e;

    function automatic int unsigned min_width(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/motor_mode_arbiter_if.sv
// motor_mode_arbiter_if: command-source and motor-drive signals of the arbiter.
//   src_sel     requested source index
//   src_valid   per-source liveness
//   src_cmd     per-source active-low command, slice k at [6k+5:6k]
//   ENA..IN4    registered active-low motor drive
//   active_src  source currently owning the motors
//   switching   outputs forced idle
// Modports: master (command side, drives sources), slave (the arbiter).
interface motor_mode_arbiter_if #(
    parameter int unsigned NUM_SRC = 2
);
    import motor_arb_pkg::*;

    localparam int unsigned SelW = min_width(NUM_SRC);

    logic [SelW-1:0]      src_sel;
    logic [NUM_SRC-1:0]   src_valid;
    logic [6*NUM_SRC-1:0] src_cmd;
    logic                 ENA;
    logic                 ENB;
    logic                 IN1;
    logic                 IN2;
    logic                 IN3;
    logic                 IN4;
    logic [SelW-1:0]      active_src;
    logic                 switching;

    modport master (
        output src_sel, src_valid, src_cmd,
        input  ENA, ENB, IN1, IN2, IN3, IN4, active_src, switching
    );

    modport slave (
        input  src_sel, src_valid, src_cmd,
        output ENA, ENB, IN1, IN2, IN3, IN4, active_src, switching
    );

endinterface

// File: rtl/arb_dwell_counter.sv
// arb_dwell_counter: all-off dwell down-counter for motor_mode_arbiter.
//   clock  sole clock
//   reset  asynchronous active-high reset, loads DEAD_CYCLES-1
//   load   reload to DEAD_CYCLES-1 (wins over dec)
//   dec    decrement, saturating at zero
//   zero   counter currently at zero
module arb_dwell_counter
    import motor_arb_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned CntW = min_width(DEAD_CYCLES);
    localparam logic [CntW-1:0] Reload = CntW'(DEAD_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = Reload;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= Reload;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/motor_mode_arbiter.sv
// motor_mode_arbiter: hands a set of motor drive lines to one of NUM_SRC command sources,
// inserting an all-off dwell of DEAD_CYCLES cycles on every ownership change.
//   clock   sole clock, rising edge
//   reset   asynchronous active-high reset (starts a dwell towards source 0)
//   bus     motor_mode_arbiter_if.slave: src_sel/src_valid/src_cmd in,
//           ENA..IN4/active_src/switching out
// Build option: MOTOR_ARB_WDOG_EN adds the valid-loss watchdog and the LOSS state;
// without it src_valid is ignored.
module motor_mode_arbiter
    import motor_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned DEAD_CYCLES = 50000,
    parameter int unsigned WDOG_CYCLES = 5000000
) (
    input  logic                 clock,
    input  logic                 reset,
    motor_mode_arbiter_if.slave  bus
);

    localparam int unsigned SelW = min_width(NUM_SRC);

    arb_state_e      state_q, state_d;
    logic [SelW-1:0] active_q, active_d;
    logic [SelW-1:0] target_q, target_d;
    logic [5:0]      out_q, out_d;
    logic            switching_q, switching_d;

    logic            dwell_load;
    logic            dwell_dec;
    logic            dwell_zero;
    logic            sel_in_range;
    logic            sel_moves;
    logic            run_hold;
    logic [5:0]      act_cmd;
    logic            wdog_expire;

    arb_dwell_counter #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_dwell (
        .clock (clock),
        .reset (reset),
        .load  (dwell_load),
        .dec   (dwell_dec),
        .zero  (dwell_zero)
    );

    assign sel_in_range = (32'(bus.src_sel) < NUM_SRC);
    assign sel_moves    = sel_in_range && (bus.src_sel != active_q);

    always_comb begin
        act_cmd = IdleCmd;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(active_q) == k) begin
                act_cmd = bus.src_cmd[6*k +: 6];
            end
        end
    end

`ifdef MOTOR_ARB_WDOG_EN
    localparam int unsigned WdogW = min_width(WDOG_CYCLES);

    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             act_valid;

    always_comb begin
        act_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (32'(active_q) == k) begin
                act_valid = bus.src_valid[k];
            end
        end
    end

    // Counts consecutive low-valid cycles of the owner, only while running.
    always_comb begin
        wdog_d      = '0;
        wdog_expire = 1'b0;
        if ((state_q == StRun) && !act_valid) begin
            if (32'(wdog_q) == WDOG_CYCLES - 1) begin
                wdog_expire = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic        unused_valid;
    logic [31:0] unused_wdog_cycles;

    assign unused_valid       = ^bus.src_valid;
    assign unused_wdog_cycles = 32'(WDOG_CYCLES);
    assign wdog_expire        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        target_d   = target_q;
        dwell_load = 1'b0;
        dwell_dec  = 1'b0;

        case (state_q)
            StRun: begin
                // A select change outranks a simultaneous watchdog expiry.
                if (sel_moves) begin
                    state_d    = StDead;
                    target_d   = bus.src_sel;
                    dwell_load = 1'b1;
                end else if (wdog_expire) begin
`ifdef MOTOR_ARB_WDOG_EN
                    state_d = StLoss;
`endif
                end
            end
            StDead: begin
                if (sel_in_range && (bus.src_sel != target_q)) begin
                    target_d   = bus.src_sel;
                    dwell_load = 1'b1;
                end else if (dwell_zero) begin
                    state_d  = StRun;
                    active_d = target_q;
                end else begin
                    dwell_dec = 1'b1;
                end
            end
`ifdef MOTOR_ARB_WDOG_EN
            StLoss: begin
                // Recovery always goes through a full dwell.
                if (sel_moves) begin
                    state_d    = StDead;
                    target_d   = bus.src_sel;
                    dwell_load = 1'b1;
                end else if (act_valid) begin
                    state_d    = StDead;
                    target_d   = active_q;
                    dwell_load = 1'b1;
                end
            end
`endif
            default: begin
                state_d    = StDead;
                dwell_load = 1'b1;
            end
        endcase

        // Drive only while running both before and after this edge: idle is immediate on
        // leaving RUN, and a new owner's command lands one cycle after entering RUN.
        run_hold    = (state_q == StRun) && (state_d == StRun);
        out_d       = run_hold ? act_cmd : IdleCmd;
        switching_d = !run_hold;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StDead;
            active_q    <= '0;
            target_q    <= '0;
            out_q       <= IdleCmd;
            switching_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            target_q    <= target_d;
            out_q       <= out_d;
            switching_q <= switching_d;
        end
    end

    assign bus.ENA        = out_q[CmdEna];
    assign bus.ENB        = out_q[CmdEnb];
    assign bus.IN1        = out_q[CmdIn1];
    assign bus.IN2        = out_q[CmdIn2];
    assign bus.IN3        = out_q[CmdIn3];
    assign bus.IN4        = out_q[CmdIn4];
    assign bus.active_src = active_q;
    assign bus.switching  = switching_q;

endmodule

// File: tb/tb_motor_mode_arbiter.sv
// tb_motor_mode_arbiter: directed scenarios plus randomized stimulus for motor_mode_arbiter,
// checked every cycle against a behavioural ownership model.
// Honours MOTOR_ARB_WDOG_EN the same way as the design.
module tb_motor_mode_arbiter;

    // Three sources so that an out-of-range select (3) is representable in the select field.
    localparam int unsigned NSRC = 3;
    localparam int unsigned DEAD = 4;
    localparam int unsigned WDOG = 8;

    localparam logic [5:0] Idle = 6'b111111;
    localparam logic [5:0] Cmd0 = 6'b010110;
    localparam logic [5:0] Cmd1 = 6'b001010;
    localparam logic [5:0] Cmd2 = 6'b100101;

    localparam int PhOwn      = 0;
    localparam int PhHandover = 1;
    localparam int PhLost     = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    // Model: who owns the motors, where a handover is heading, how many dwell cycles have
    // elapsed, how long the owner has been silent, and the outputs expected after the edge.
    int         m_phase = PhHandover;
    int         m_owner = 0;
    int         m_goal  = 0;
    int         m_spent = 0;
    int         m_low   = 0;
    logic [5:0] e_cmd   = Idle;
    logic       e_sw    = 1'b1;
    int         e_owner = 0;

    motor_mode_arbiter_if #(.NUM_SRC(NSRC)) bus ();

    motor_mode_arbiter #(
        .NUM_SRC     (NSRC),
        .DEAD_CYCLES (DEAD),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_phase = PhHandover;
        m_owner = 0;
        m_goal  = 0;
        m_spent = 0;
        m_low   = 0;
        e_cmd   = Idle;
        e_sw    = 1'b1;
        e_owner = 0;
    endtask

    task automatic model_step();
        int         sel;
        bit         in_rng;
        bit         live;
        int         prev;
        logic [5:0] cur;
        sel    = int'(bus.src_sel);
        in_rng = (sel < NSRC);
`ifdef MOTOR_ARB_WDOG_EN
        live = bus.src_valid[m_owner];
`else
        live = 1'b1;
`endif
        cur  = bus.src_cmd[6*m_owner +: 6];
        prev = m_phase;
        if (m_phase == PhOwn) begin
            if (in_rng && sel != m_owner) begin
                m_phase = PhHandover;
                m_goal  = sel;
                m_spent = 0;
            end else if (!live && (m_low + 1 == WDOG)) begin
                m_phase = PhLost;
            end
        end else if (m_phase == PhHandover) begin
            if (in_rng && sel != m_goal) begin
                m_goal  = sel;
                m_spent = 0;
            end else begin
                m_spent++;
                if (m_spent == DEAD) begin
                    m_phase = PhOwn;
                    m_owner = m_goal;
                end
            end
        end else begin
            if (in_rng && sel != m_owner) begin
                m_phase = PhHandover;
                m_goal  = sel;
                m_spent = 0;
            end else if (live) begin
                m_phase = PhHandover;
                m_goal  = m_owner;
                m_spent = 0;
            end
        end
        m_low   = (prev == PhOwn && m_phase == PhOwn && !live) ? m_low + 1 : 0;
        e_cmd   = (prev == PhOwn && m_phase == PhOwn) ? cur : Idle;
        e_sw    = !(prev == PhOwn && m_phase == PhOwn);
        e_owner = m_owner;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check(string name, logic [5:0] cmd_exp, logic sw_exp, int own_exp);
        logic [5:0] cmd_act;
        cmd_act = {bus.ENA, bus.ENB, bus.IN1, bus.IN2, bus.IN3, bus.IN4};
        n_vec++;
        if (cmd_act !== cmd_exp) begin
            n_bad++;
            $display("FAIL %s cmd: got %b want %b at %0t", name, cmd_act, cmd_exp, $time);
        end
        if (bus.switching !== sw_exp) begin
            n_bad++;
            $display("FAIL %s switching: got %b want %b at %0t", name, bus.switching, sw_exp,
                     $time);
        end
        if (bus.active_src !== 2'(own_exp)) begin
            n_bad++;
            $display("FAIL %s active_src: got %0d want %0d at %0t", name, bus.active_src,
                     own_exp, $time);
        end
    endtask

    // Literal expectation: checks the DUT and also pins the model to the same value.
    task automatic check_lit(string name, logic [5:0] cmd_exp, logic sw_exp, int own_exp);
        check(name, cmd_exp, sw_exp, own_exp);
        n_vec++;
        if (e_cmd !== cmd_exp || e_sw !== sw_exp || e_owner != own_exp) begin
            n_bad++;
            $display("FAIL model_%s: got %b/%b/%0d want %b/%b/%0d", name, e_cmd, e_sw, e_owner,
                     cmd_exp, sw_exp, own_exp);
        end
    endtask

    always @(negedge clock) check("model", e_cmd, e_sw, e_owner);

    // Select already changed: one idle sample for the switching edge, DEAD dwell samples
    // (owner flips on the last), then the new owner's command.
    task automatic handover(string name, int from, int to, logic [5:0] cmd_new);
        for (int i = 0; i <= DEAD; i++) begin
            @(negedge clock);
            check_lit(name, Idle, 1'b1, (i == DEAD) ? to : from);
        end
        @(negedge clock);
        check_lit(name, cmd_new, 1'b0, to);
    endtask

    task automatic powerup(string name);
        for (int i = 0; i < DEAD; i++) begin
            @(negedge clock);
            check_lit(name, Idle, 1'b1, 0);
        end
        @(negedge clock);
        check_lit(name, Cmd0, 1'b0, 0);
    endtask

    initial begin
        logic [31:0] r;
        bit          lowmode;
        bus.src_sel   = '0;
        bus.src_valid = '1;
        bus.src_cmd   = {Cmd2, Cmd1, Cmd0};
        reset         = 1'b1;
        repeat (2) @(negedge clock);
        check_lit("reset_idle", Idle, 1'b1, 0);
        reset = 1'b0;
        powerup("powerup");

        // Dwell towards 1, then back to 0 two cycles in: the dwell restarts.
        bus.src_sel = 1;
        repeat (2) begin
            @(negedge clock);
            check_lit("dwell_to1", Idle, 1'b1, 0);
        end
        bus.src_sel = 0;
        handover("redwell", 0, 0, Cmd0);

        bus.src_sel = 1;
        handover("switch_to1", 0, 1, Cmd1);

        bus.src_sel = 2'd3;
        repeat (3) begin
            @(negedge clock);
            check_lit("sel_out_of_range", Cmd1, 1'b0, 1);
        end
        bus.src_cmd[11:6] = 6'b110011;
        @(negedge clock);
        check_lit("cmd_follow", 6'b110011, 1'b0, 1);
        bus.src_cmd[11:6] = Cmd1;

        bus.src_sel = 0;
        handover("switch_to0", 1, 0, Cmd0);

`ifdef MOTOR_ARB_WDOG_EN
        bus.src_valid[0] = 1'b0;
        repeat (WDOG - 1) begin
            @(negedge clock);
            check_lit("wdog_short", Cmd0, 1'b0, 0);
        end
        bus.src_valid[0] = 1'b1;
        @(negedge clock);
        check_lit("wdog_short", Cmd0, 1'b0, 0);
        bus.src_valid[0] = 1'b0;
        repeat (WDOG - 1) begin
            @(negedge clock);
            check_lit("wdog_count", Cmd0, 1'b0, 0);
        end
        repeat (3) begin
            @(negedge clock);
            check_lit("wdog_loss", Idle, 1'b1, 0);
        end
        bus.src_valid[0] = 1'b1;
        handover("wdog_recover", 0, 0, Cmd0);
`else
        bus.src_valid = '0;
        repeat (100) begin
            @(negedge clock);
            check_lit("no_wdog", Cmd0, 1'b0, 0);
        end
        bus.src_valid = '1;
`endif

        // Asynchronous reset mid-RUN: idle immediately, then the power-up dwell again.
        #2 reset = 1'b1;
        #1 check_lit("async_reset", Idle, 1'b1, 0);
        @(negedge clock);
        reset = 1'b0;
        powerup("reset_restart");

        lowmode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if ($urandom_range(0, 7) == 0) bus.src_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                r           = $urandom;
                bus.src_cmd = r[17:0];
            end
            if ($urandom_range(0, 15) == 0) lowmode = !lowmode;
            if (lowmode) bus.src_valid = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'b000;
            else         bus.src_valid = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
            reset = ($urandom_range(0, 799) == 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
